inst_fetch: RTL and testbench

Instruction fetch stage of the RV32I core. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It registers each returned instruction with its address into the IF/ID slot that feeds instruction decode. It redirects on EX jumps, squashes wrong-path fetches, and holds its output under pipeline stall using a one-entry skid buffer.

---
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch.sv | 157 +++++++++++++++
 tb/tb_inst_fetch.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-memory fetch bus: request/grant out of the fetch stage,
// response (rvalid/rdata) back from memory.
interface inst_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  // Fetch stage side
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  // Instruction memory side
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage: owns the PC, issues one word fetch at a
// time over the imem handshake, squashes wrong-path responses after a
// jump, and holds the IF/ID slot under stall with a one-entry skid buffer.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                jump_flag_i,
  input  logic [31:0]         jump_addr_i,
  input  logic                hold_i,
  inst_fetch_if.master        imem,
  output logic [31:0]         inst_o,
  output logic [31:0]         inst_addr_o,
  output logic                inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] req_addr_q;
  logic        kill_q;
  logic        kill_d;

  logic        buf_full;
  logic        buf_full_d;
  logic        buf_load;
  logic [31:0] buf_inst;
  logic [31:0] buf_addr;

  logic [31:0] inst_d;
  logic [31:0] inst_addr_d;
  logic        inst_valid_d;

  logic        req;
  logic        gnt_fire;
  logic        rsp;
  logic        rsp_good;
  logic [31:0] jump_target;

  // Jump targets are word aligned; the low address bits are dropped.
  logic        unused_jump_lsb;
  assign unused_jump_lsb = &{1'b0, jump_addr_i[1:0]};
  assign jump_target     = {jump_addr_i[31:2], 2'b00};

  // A request is withheld while the skid buffer is occupied (so it can
  // never overflow) and during a jump (the PC is about to change).
  assign req      = (state_q == S_REQ) & ~buf_full & ~jump_flag_i;
  assign gnt_fire = req & imem.imem_gnt_i;
  // Responses only count while a request is outstanding.
  assign rsp      = (state_q == S_WAIT) & imem.imem_rvalid_i;
  assign rsp_good = rsp & ~kill_q;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  // FSM next state: one outstanding fetch at a time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (gnt_fire) state_d = S_WAIT;
      S_WAIT:  if (imem.imem_rvalid_i) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Next PC and stale-response tracking; a jump overrides any grant.
  always_comb begin
    pc_d   = pc_q;
    kill_d = kill_q;
    if (jump_flag_i) begin
      pc_d = jump_target;
    end else if (gnt_fire) begin
      pc_d = pc_q + 32'd4;
    end
    // A jump while waiting with nothing returned yet leaves a wrong-path
    // response in flight; the next rvalid drains it and clears the flag.
    if (jump_flag_i && (state_q == S_WAIT) && !imem.imem_rvalid_i) begin
      kill_d = 1'b1;
    end else if (rsp) begin
      kill_d = 1'b0;
    end
  end

  // IF/ID slot update: jump, then hold, then buffered word, then fresh word.
  always_comb begin
    inst_valid_d = 1'b0;
    inst_d       = NOP_INST;
    inst_addr_d  = 32'h0;
    buf_full_d   = buf_full;
    buf_load     = 1'b0;
    if (jump_flag_i) begin
      buf_full_d = 1'b0;
    end else if (hold_i) begin
      inst_valid_d = inst_valid_o;
      inst_d       = inst_o;
      inst_addr_d  = inst_addr_o;
      if (rsp_good) begin
        buf_full_d = 1'b1;
        buf_load   = 1'b1;
      end
    end else if (buf_full) begin
      inst_valid_d = 1'b1;
      inst_d       = buf_inst;
      inst_addr_d  = buf_addr;
      buf_full_d   = 1'b0;
    end else if (rsp_good) begin
      inst_valid_d = 1'b1;
      inst_d       = imem.imem_rdata_i;
      inst_addr_d  = req_addr_q;
    end
  end

  // Control and IF/ID state registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      buf_full     <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      buf_full     <= buf_full_d;
      inst_valid_o <= inst_valid_d;
      inst_o       <= inst_d;
      inst_addr_o  <= inst_addr_d;
    end
  end

  // Data-only registers: outstanding request address and skid buffer
  // contents, qualified by their own control flags.
  always_ff @(posedge clk_i) begin
    if (gnt_fire) begin
      req_addr_q <= pc_q;
    end
    if (buf_load) begin
      buf_inst <= imem.imem_rdata_i;
      buf_addr <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed stimulus with a scoreboard of expected
// fetch addresses and expected IF/ID words, checked by a separate monitor.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        jump;
  logic [31:0] jaddr;
  logic        hold;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst2;
  logic [31:0] inst_addr2;
  logic        inst_valid2;

  int          checks;
  int          errors;
  logic        hold_seen;
  logic [31:0] req_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] mon_addr;
  logic [63:0] mon_word;

  inst_fetch_if bus ();
  inst_fetch_if bus2 ();

  assign bus.imem_gnt_i     = gnt;
  assign bus.imem_rvalid_i  = rvalid;
  assign bus.imem_rdata_i   = rdata;
  assign bus2.imem_gnt_i    = gnt;
  assign bus2.imem_rvalid_i = rvalid;
  assign bus2.imem_rdata_i  = rdata;

  inst_fetch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .jump_flag_i  (jump),
    .jump_addr_i  (jaddr),
    .hold_i       (hold),
    .imem         (bus),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .jump_flag_i  (jump),
    .jump_addr_i  (jaddr),
    .hold_i       (hold),
    .imem         (bus2),
    .inst_o       (inst2),
    .inst_addr_o  (inst_addr2),
    .inst_valid_o (inst_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // hold_i as seen by the DUT at the last edge: a valid output after a
  // non-held edge is a freshly loaded instruction.
  always @(posedge clk) hold_seen <= hold;

  // Monitor: pops the scoreboard whenever a request is granted or a new
  // instruction is presented on IF/ID.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req_o && gnt) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_req_unexpected actual=%h expected=none", bus.imem_addr_o);
        end else begin
          mon_addr = req_q.pop_front();
          chk("mon_req_addr", bus.imem_addr_o, mon_addr);
        end
      end
      if (inst_valid && !hold_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_inst_unexpected actual=%h@%h expected=none", inst, inst_addr);
        end else begin
          mon_word = exp_q.pop_front();
          chk("mon_inst", inst, mon_word[63:32]);
          chk("mon_inst_addr", inst_addr, mon_word[31:0]);
        end
      end
    end
  end

  // One fetch from the REQ state: grant a cycle after req, respond a
  // cycle after grant; returns just after the word reaches IF/ID.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    #1;
    chk("fetch_req", {31'h0, bus.imem_req_o}, 32'h1);
    chk("fetch_addr", bus.imem_addr_o, a);
    gnt = 1'b0;
    cyc();
    gnt = 1'b1;
    req_q.push_back(a);
    cyc();
    gnt = 1'b0;
    chk("fetch_bubble", {31'h0, inst_valid}, 32'h0);
    rvalid = 1'b1;
    rdata  = d;
    exp_q.push_back({d, a});
    cyc();
    rvalid = 1'b0;
    chk("fetch_valid", {31'h0, inst_valid}, 32'h1);
    chk("fetch_inst", inst, d);
    chk("fetch_inst_addr", inst_addr, a);
  endtask

  task automatic chk_frozen(input string name);
    chk(name, inst, 32'h0030_0193);
    chk(name, inst_addr, 32'h0000_0100);
    chk(name, {31'h0, inst_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    jump   = 1'b0;
    jaddr  = 32'h0;
    hold   = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'h0;
    cyc();
    cyc();

    // Reset values
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_req", {31'h0, bus.imem_req_o}, 32'h0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst2_addr", bus2.imem_addr_o, 32'hFFFF_FFFC);
    chk("rst2_inst", inst2, 32'h0000_0013);
    chk("rst2_valid", {31'h0, inst_valid2}, 32'h0);

    // First cycle after release is IDLE, request on the second
    rst_n = 1'b1;
    #1;
    chk("idle_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    #1;
    chk("rst2_first_req", {31'h0, bus2.imem_req_o}, 32'h1);
    chk("rst2_first_addr", bus2.imem_addr_o, 32'hFFFF_FFFC);

    // Two sequential fetches
    do_fetch(32'h0, 32'h0010_0093);
    #1;
    chk("rst2_wrap_req", {31'h0, bus2.imem_req_o}, 32'h1);
    chk("rst2_wrap_addr", bus2.imem_addr_o, 32'h0);
    do_fetch(32'h4, 32'h0020_0113);

    // Jump while waiting on the fetch of 0x8; stale response later
    gnt = 1'b1;
    req_q.push_back(32'h8);
    cyc();
    gnt   = 1'b0;
    jump  = 1'b1;
    jaddr = 32'h0000_0102;
    #1;
    chk("jump_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    jump = 1'b0;
    #1;
    chk("jump_bubble", {31'h0, inst_valid}, 32'h0);
    chk("jump_inst_nop", inst, 32'h0000_0013);
    chk("jump_pc", bus.imem_addr_o, 32'h0000_0100);
    chk("kill_wait_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    cyc();
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    cyc();
    rvalid = 1'b0;
    chk("stale_dropped", {31'h0, inst_valid}, 32'h0);
    do_fetch(32'h100, 32'h0030_0193);

    // Hold for 4 cycles, good response in the 2nd held cycle
    hold = 1'b1;
    gnt  = 1'b1;
    req_q.push_back(32'h104);
    cyc();
    gnt = 1'b0;
    chk_frozen("hold_frozen1");
    rvalid = 1'b1;
    rdata  = 32'h0040_0213;
    exp_q.push_back({32'h0040_0213, 32'h104});
    cyc();
    rvalid = 1'b0;
    #1;
    chk_frozen("hold_frozen2");
    chk("buf_full_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    #1;
    chk_frozen("hold_frozen3");
    chk("buf_full_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    hold = 1'b0;
    #1;
    chk_frozen("hold_frozen4");
    chk("buf_full_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    chk("unhold_valid", {31'h0, inst_valid}, 32'h1);
    chk("unhold_inst", inst, 32'h0040_0213);
    chk("unhold_inst_addr", inst_addr, 32'h104);
    do_fetch(32'h108, 32'h0050_0293);

    // Fill the buffer, then jump and hold together
    hold = 1'b1;
    gnt  = 1'b1;
    req_q.push_back(32'h10C);
    cyc();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0060_0313;
    cyc();
    rvalid = 1'b0;
    jump   = 1'b1;
    jaddr  = 32'h0000_0200;
    #1;
    chk("jh_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    jump = 1'b0;
    hold = 1'b0;
    chk("jh_bubble", {31'h0, inst_valid}, 32'h0);
    chk("jh_inst_nop", inst, 32'h0000_0013);
    chk("jh_inst_addr", inst_addr, 32'h0);
    do_fetch(32'h200, 32'h0070_0393);

    // Asynchronous reset in the middle of WAIT
    gnt = 1'b1;
    req_q.push_back(32'h204);
    cyc();
    gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_inst", inst, 32'h0000_0013);
    chk("arst_req", {31'h0, bus.imem_req_o}, 32'h0);
    chk("arst_addr", bus.imem_addr_o, 32'h0);
    cyc();
    rst_n  = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'h0080_0413;
    #1;
    chk("arst_idle_no_req", {31'h0, bus.imem_req_o}, 32'h0);
    cyc();
    #1;
    chk("arst_req_pc", bus.imem_addr_o, 32'h0);
    cyc();
    rvalid = 1'b0;
    chk("arst_rsp_ignored", {31'h0, inst_valid}, 32'h0);
    do_fetch(32'h0, 32'h0090_0493);

    cyc();
    cyc();
    chk("req_q_drained", req_q.size(), 32'h0);
    chk("exp_q_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
